// File: rtl/y_argmax_seq_pkg.sv
// Shared constants and FSM encoding for the sequential argmax/sum block.
package y_argmax_seq_pkg;

    localparam int unsigned N    = 9;
    localparam int unsigned W    = 20;
    localparam int unsigned IDXW = 4;
    localparam int unsigned SW   = 24;

    // Most-negative W-bit value; seeds the running max so any element can win.
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/y_argmax_seq_if.sv
// Input set / result handshake bundle between producer, argmax block and consumer.
interface y_argmax_seq_if;
    import y_argmax_seq_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [N*W-1:0]         y_flat;
    logic                   out_valid;
    logic                   out_ready;
    logic [IDXW-1:0]        max_idx;
    logic signed [W-1:0]    max_val;
    logic signed [SW-1:0]   sum_val;

    // Environment side: supplies sets and accepts results.
    modport master (
        output in_valid,
        output y_flat,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  max_idx,
        input  max_val,
        input  sum_val
    );

    // Block side.
    modport slave (
        input  in_valid,
        input  y_flat,
        input  out_ready,
        output in_ready,
        output out_valid,
        output max_idx,
        output max_val,
        output sum_val
    );

endinterface

// File: rtl/y_cmp_acc.sv
// One combinational scan step: strict signed max update and sign-extended accumulate.
module y_cmp_acc
    import y_argmax_seq_pkg::*;
(
    input  logic signed [W-1:0]   elem,
    input  logic [IDXW-1:0]       cnt,
    input  logic signed [W-1:0]   run_max,
    input  logic [IDXW-1:0]       run_idx,
    input  logic signed [SW-1:0]  run_sum,
    output logic signed [W-1:0]   nxt_max,
    output logic [IDXW-1:0]       nxt_idx,
    output logic signed [SW-1:0]  nxt_sum
);

    logic signed [SW-1:0] elem_ext;

    // Strict compare keeps the earliest index on ties; sum width cannot overflow.
    always_comb begin
        nxt_max  = run_max;
        nxt_idx  = run_idx;
        elem_ext = {{(SW-W){elem[W-1]}}, elem};
        if (elem > run_max) begin
            nxt_max = elem;
            nxt_idx = cnt;
        end
        nxt_sum = run_sum + elem_ext;
    end

endmodule

// File: rtl/y_argmax_seq.sv
// Captures a set of N signed elements, scans one per cycle, reports argmax and sum.
module y_argmax_seq
    import y_argmax_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    y_argmax_seq_if.slave bus
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t               state_q, state_d;
    logic [IDXW-1:0]      cnt_q;
    logic signed [W-1:0]  elem_q [N];
    logic signed [W-1:0]  run_max_q;
    logic [IDXW-1:0]      run_idx_q;
    logic signed [SW-1:0] run_sum_q;
    logic [IDXW-1:0]      max_idx_q;
    logic signed [W-1:0]  max_val_q;
    logic signed [SW-1:0] sum_val_q;

    logic signed [W-1:0]  nxt_max;
    logic [IDXW-1:0]      nxt_idx;
    logic signed [SW-1:0] nxt_sum;
    logic                 accept;
    logic                 last_step;

    assign accept    = (state_q == StIdle) && bus.in_valid;
    assign last_step = (state_q == StScan) && (cnt_q == LAST_IDX);

    y_cmp_acc u_cmp_acc (
        .elem    (elem_q[cnt_q]),
        .cnt     (cnt_q),
        .run_max (run_max_q),
        .run_idx (run_idx_q),
        .run_sum (run_sum_q),
        .nxt_max (nxt_max),
        .nxt_idx (nxt_idx),
        .nxt_sum (nxt_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StScan;
            StScan:  if (last_step)     state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture on acceptance, step the running values during the scan, load results at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            run_max_q <= MIN_VAL;
            run_idx_q <= '0;
            run_sum_q <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
            sum_val_q <= '0;
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q     <= '0;
            run_max_q <= MIN_VAL;
            run_idx_q <= '0;
            run_sum_q <= '0;
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= bus.y_flat[i*W +: W];
            end
        end else if (state_q == StScan) begin
            run_max_q <= nxt_max;
            run_idx_q <= nxt_idx;
            run_sum_q <= nxt_sum;
            if (last_step) begin
                cnt_q     <= '0;
                max_idx_q <= nxt_idx;
                max_val_q <= nxt_max;
                sum_val_q <= nxt_sum;
            end else begin
                cnt_q <= cnt_q + IDXW'(1);
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.max_idx   = max_idx_q;
    assign bus.max_val   = max_val_q;
    assign bus.sum_val   = sum_val_q;

endmodule

// File: tb/tb_y_argmax_seq.sv
// Scoreboard bench for y_argmax_seq: directed test-plan sets, random sets, backpressure, reset.
module tb_y_argmax_seq;
    import y_argmax_seq_pkg::*;

    typedef logic signed [W-1:0] set_t [N];
    typedef struct packed {
        logic [IDXW-1:0]      idx;
        logic signed [W-1:0]  val;
        logic signed [SW-1:0] sum;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb [$];

    y_argmax_seq_if bus ();

    y_argmax_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input set_t v);
        exp_t e;
        e.val = MIN_VAL;
        e.idx = '0;
        e.sum = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i] > e.val) begin
                e.val = v[i];
                e.idx = IDXW'(i);
            end
            e.sum = e.sum + SW'(v[i]);
        end
        return e;
    endfunction

    task automatic send(input set_t v, input exp_t e);
        int cyc;
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        for (int i = 0; i < N; i++) bus.y_flat[i*W +: W] = v[i];
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(e);
    endtask

    // Waits for out_valid (checking the N-cycle latency) and compares against the scoreboard.
    task automatic collect(input bit scramble);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            if (scramble) begin
                for (int i = 0; i < N; i++) bus.y_flat[i*W +: W] = W'($urandom);
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (cyc != N || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency: cycles=%0d out_valid=%b required %0d cycles", cyc, bus.out_valid, N);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: size=0 required >0");
            return;
        end
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1) return;
        checks += 3;
        if (bus.max_idx !== e.idx) begin
            failures++;
            $display("FAIL max_idx: got %0d required %0d", bus.max_idx, e.idx);
        end
        if (bus.max_val !== e.val) begin
            failures++;
            $display("FAIL max_val: got %0d required %0d", bus.max_val, e.val);
        end
        if (bus.sum_val !== e.sum) begin
            failures++;
            $display("FAIL sum_val: got %0d required %0d", bus.sum_val, e.sum);
        end
    endtask

    task automatic check_idle(input string name, input bit zero_outputs);
        checks += 2;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s out_valid: got %b required 0", name, bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready: got %b required 1", name, bus.in_ready);
        end
        if (zero_outputs) begin
            checks++;
            if (bus.max_idx !== '0 || bus.max_val !== '0 || bus.sum_val !== '0) begin
                failures++;
                $display("FAIL %s outputs: idx=%0d val=%0d sum=%0d required 0 0 0",
                         name, bus.max_idx, bus.max_val, bus.sum_val);
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.y_flat    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("reset_release", 1'b1);
    endtask

    task automatic test_ascending();
        set_t v;
        v = '{20'sd0, 20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd5, 20'sd6, 20'sd7, 20'sd8};
        bus.out_ready = 1'b1;
        send(v, '{idx: 4'd8, val: 20'sd8, sum: 24'sd36});
        collect(1'b0);
        // out_ready held high: DONE lasts one cycle.
        @(posedge clk); #1;
        check_idle("ascending_after", 1'b0);
    endtask

    task automatic test_tie();
        set_t v;
        v = '{-20'sd5, 20'sd100, -20'sd3, 20'sd100, 20'sd7, 20'sd0, -20'sd1, 20'sd2, -20'sd200};
        bus.out_ready = 1'b1;
        send(v, '{idx: 4'd1, val: 20'sd100, sum: 24'sd0});
        collect(1'b0);
    endtask

    task automatic test_all_min();
        set_t v;
        for (int i = 0; i < N; i++) v[i] = MIN_VAL;
        bus.out_ready = 1'b1;
        send(v, '{idx: 4'd0, val: MIN_VAL, sum: -24'sd4718592});
        collect(1'b0);
    endtask

    task automatic test_backpressure();
        set_t v;
        logic [IDXW-1:0]      idx0;
        logic signed [W-1:0]  val0;
        logic signed [SW-1:0] sum0;
        for (int i = 0; i < N; i++) v[i] = 20'sd524287;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(v, '{idx: 4'd0, val: 20'sd524287, sum: 24'sd4718583});
        collect(1'b0);
        idx0 = bus.max_idx;
        val0 = bus.max_val;
        sum0 = bus.sum_val;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < N; i++) bus.y_flat[i*W +: W] = -W'(c + 1);
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.max_idx !== idx0 ||
                bus.max_val !== val0 || bus.sum_val !== sum0) begin
                failures++;
                $display("FAIL hold cyc%0d: ov=%b ir=%b idx=%0d val=%0d sum=%0d required 1 0 %0d %0d %0d",
                         c, bus.out_valid, bus.in_ready, bus.max_idx, bus.max_val, bus.sum_val,
                         idx0, val0, sum0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check_idle("backpressure_release", 1'b0);
        checks++;
        if (bus.max_idx !== 4'd0 || bus.sum_val !== 24'sd4718583) begin
            failures++;
            $display("FAIL fields_kept: idx=%0d sum=%0d required 0 4718583", bus.max_idx, bus.sum_val);
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle("ignored_in_valid", 1'b0);
    endtask

    task automatic test_sample_once();
        set_t v;
        v = '{20'sd3, -20'sd9, 20'sd42, 20'sd1, 20'sd42, -20'sd100, 20'sd0, 20'sd5, 20'sd41};
        bus.out_ready = 1'b1;
        send(v, '{idx: 4'd2, val: 20'sd42, sum: 24'sd25});
        collect(1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        set_t v;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N; i++) begin
                if (s < 2) begin
                    v[i] = W'($urandom);
                end else begin
                    int t;
                    t = $urandom_range(0, 6);
                    v[i] = W'(t - 3);
                end
            end
            bus.out_ready = 1'b1;
            send(v, model(v));
            collect(1'b0);
        end
    endtask

    task automatic test_mid_reset();
        set_t v;
        for (int i = 0; i < N; i++) v[i] = W'(i * 1000 - 4000);
        bus.out_ready = 1'b1;
        send(v, model(v));
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset", 1'b1);
        void'(sb.pop_front());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("mid_reset_release", 1'b1);
        v = '{-20'sd7, 20'sd12, 20'sd900, -20'sd300, 20'sd899, 20'sd900, 20'sd0, 20'sd1, -20'sd5};
        send(v, '{idx: 4'd2, val: 20'sd900, sum: 24'sd2400});
        collect(1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ascending();
        test_tie();
        test_all_min();
        test_backpressure();
        test_sample_once();
        test_random();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
